sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Shares the 32-bit BaseRAM between the CPU instruction-fetch port and the data-memory port, and sequences the asynchronous SRAM control pins (CE#/OE#/WE#/BE#, tri-state data) through a multi-cycle read/write FSM. It sits between the pipeline's IF/MEM stages and the `base_ram_*` top-level pins of `riscv_cpu_top`. Requests use req/ack; round-robin resolves simultaneous requests; all SRAM pins are registered.

## Interface
- `RD_WAIT`, default 1: extra cycles OE# is held low before read data is sampled (range 0–7).
- `WR_PULSE`, default 1: number of cycles WE# is held low (range 1–7).
- `clk_50M`  in  1  system clock; every flop is clocked on its rising edge.
- `reset_btn`  in  1  synchronous, active-high reset.
- `if_req`  in  1  fetch request, read-only; held until `if_ack`.
- `if_addr`  in  32  fetch byte address; `[21:2]` is used.
- `if_ack`  out  1  one-cycle completion pulse.
- `if_rdata`  out  32  fetched word; valid when `if_ack`=1 and held until the next fetch ack.
- `d_req`  in  1  data request; held until `d_ack`.
- `d_we`  in  1  1 = write, 0 = read.
- `d_addr`  in  32  data byte address; `[21:2]` is used.
- `d_be`  in  4  active-high byte enables for writes; ignored on reads.
- `d_wdata`  in  32  write data.
- `d_ack`  out  1  one-cycle completion pulse.
- `d_rdata`  out  32  read word; valid when `d_ack`=1 and held until the next data read ack.
- `busy`  out  1  high in any state other than IDLE.
- `base_ram_addr`  out  20  SRAM word address.
- `base_ram_ce_n`, `base_ram_oe_n`, `base_ram_we_n`  out  1 each  active-low SRAM controls.
- `base_ram_be_n`  out  4  active-low byte lanes.
- `base_ram_data`  inout  32  driven only in write states, high-Z otherwise.

## Operation
- States are IDLE, RD, WS (write setup), WP (write pulse), WH (write hold) and DONE.
- **Reset values:** addr=0, ce_n=1, oe_n=1, we_n=1, be_n=4'hF, data=Z, acks=0, rdatas=0, busy=0, state=IDLE, last_grant=IF.
- **Arbitration** happens in IDLE only:
  - If only one port requests, that port is granted.
  - If both request, the port not granted last time wins. With last_grant=IF after reset, the data port wins the first tie.
  - The grant, address, be, we and wdata are latched at the grant.
- **IDLE → RD** on a read grant:
  - Drives ce_n=0, oe_n=0, be_n=0000, addr=addr[21:2].
  - A counter loads `RD_WAIT`.
- **RD:**
  - While the counter is non-zero, it decrements.
  - When the counter is 0, `base_ram_data` is sampled into the granted port's rdata register, ce_n and oe_n go to 1, and the FSM moves to DONE.
- **IDLE → WS** on a data write grant:
  - Drives ce_n=0, we_n=1, be_n=~d_be, addr, and data=d_wdata (output enabled).
- **WS → WP:** we_n=0 and the counter loads `WR_PULSE`-1.
- **WP:** stays while the counter is non-zero, then moves to WH with we_n=1. Data, addr and be are unchanged.
- **WH → DONE:** ce_n=1, data is released to Z, be_n=1111.
- **DONE:** the granted port's ack is 1 for exactly one cycle; last_grant is updated; next state is IDLE.
- **Requester rules:**
  - A requester drops req on the edge where it sees ack. IDLE therefore never re-grants a stale request.
  - A req raised while busy waits; it is never dropped.
  - The fetch port is never granted a write.
- **Reset mid-operation:**
  - The next edge forces IDLE and reset values on all pins, which immediately truncates any WE# pulse.
  - No ack is issued and the in-flight access is abandoned.
- `addr[1:0]` and `addr[31:22]` are ignored. Address decode is done upstream.

## Timing
- Cycle numbering: request seen high in IDLE at edge T.
- **Read:**
  - The SRAM pins show the access from T+1.
  - Data is sampled at the end of cycle T+1+`RD_WAIT`.
  - Ack is at T+2+`RD_WAIT` (T+3 with defaults).
  - OE# low for `RD_WAIT`+1 cycles.
- **Write:**
  - Ack is at T+3+`WR_PULSE` (T+4 with defaults).
  - Address, BE# and data are stable for one cycle before WE# falls and one cycle after it rises.
- **Throughput:** back-to-back requests from the same port need one IDLE cycle between accesses. With a default read every 4 cycles, a new request is granted in the IDLE cycle immediately after DONE.
- **Pin conventions:**
  - OE# and WE# are never low in the same cycle.
  - The data bus is driven only while WE# = 1/0/1 within WS/WP/WH.

## Test plan
- **Reset:** assert `reset_btn` 2 cycles → all pins at reset values, data = Z, busy=0; no ack for 10 cycles with no reqs.
- **Single read:** word 0x80000004 preloaded 0x00A00093; `if_req` with `if_addr`=0x80000004 → addr=0x00001, OE# low 2 cycles, `if_ack` at T+3, `if_rdata`=0x00A00093.
- **Byte write:** `d_we`=1, `d_be`=0100, `d_addr`=0x80300000, wdata=0x00040000 → be_n=1011, WE# low exactly 1 cycle, mem byte2 of word 0xC0000 = 0x04, other bytes unchanged, `d_ack` at T+4.
- **Contention:** both reqs high from reset → data granted first, then fetch. Then both re-request → data again, since the last grant was fetch. Data ack precedes fetch ack by 4 cycles for reads.
- **Reset mid-write:** assert reset in WP → next cycle we_n=1, ce_n=1, data=Z, no `d_ack`. After release, a new read proceeds normally.
- **Parameter sweep:** `RD_WAIT`=3, `WR_PULSE`=2 → read ack at T+5, WE# low 2 cycles, write ack at T+5.

Source files
------------

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : sram_arbiter
// Brief   : Round-robin arbiter that shares the BaseRAM between the fetch and
//           data ports and sequences the async SRAM pins through a read/write FSM.
// Revision: 1.0  initial release
// ============================================================================
module sram_arbiter #(
    parameter int RD_WAIT  = 1,
    parameter int WR_PULSE = 1
) (
    input  logic        clk_50M,
    input  logic        reset_btn,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        busy,
    output logic [19:0] base_ram_addr,
    output logic        base_ram_ce_n,
    output logic        base_ram_oe_n,
    output logic        base_ram_we_n,
    output logic [3:0]  base_ram_be_n,
    inout  wire  [31:0] base_ram_data
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WS   = 3'd2,
        S_WP   = 3'd3,
        S_WH   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        gnt_data_q, gnt_data_d;     // 1 = data port owns the access
    logic        last_data_q, last_data_d;   // 1 = data port was granted last
    logic [19:0] addr_q, addr_d;
    logic        ce_n_q, ce_n_d;
    logic        oe_n_q, oe_n_d;
    logic        we_n_q, we_n_d;
    logic [3:0]  be_n_q, be_n_d;
    logic        data_oe_q, data_oe_d;
    logic [31:0] wdata_q, wdata_d;
    logic        if_ack_q, if_ack_d;
    logic        d_ack_q, d_ack_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic        w_pick_data;
    logic        w_unused_bits;

    assign w_unused_bits = &{1'b0, if_addr[31:22], if_addr[1:0], d_addr[31:22], d_addr[1:0]};

    // On a tie the port that did not win last time is chosen.
    assign w_pick_data = d_req & (~if_req | ~last_data_q);

    always_ff @(posedge clk_50M) begin
        if (reset_btn) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            gnt_data_q  <= 1'b0;
            last_data_q <= 1'b0;
            addr_q      <= 20'd0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            be_n_q      <= 4'hF;
            data_oe_q   <= 1'b0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_rdata_q  <= 32'd0;
            d_rdata_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_data_q  <= gnt_data_d;
            last_data_q <= last_data_d;
            addr_q      <= addr_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            be_n_q      <= be_n_d;
            data_oe_q   <= data_oe_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
        wdata_q <= wdata_d;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_data_d  = gnt_data_q;
        last_data_d = last_data_q;
        addr_d      = addr_q;
        ce_n_d      = ce_n_q;
        oe_n_d      = oe_n_q;
        we_n_d      = we_n_q;
        be_n_d      = be_n_q;
        data_oe_d   = data_oe_q;
        wdata_d     = wdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (if_req || d_req) begin
                    gnt_data_d = w_pick_data;
                    addr_d     = w_pick_data ? d_addr[21:2] : if_addr[21:2];
                    ce_n_d     = 1'b0;
                    if (w_pick_data && d_we) begin
                        state_d   = S_WS;
                        we_n_d    = 1'b1;
                        be_n_d    = ~d_be;
                        wdata_d   = d_wdata;
                        data_oe_d = 1'b1;
                    end else begin
                        state_d = S_RD;
                        oe_n_d  = 1'b0;
                        be_n_d  = 4'h0;
                        cnt_d   = 3'(RD_WAIT);
                    end
                end
            end
            S_RD: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    if (gnt_data_q) begin
                        d_rdata_d = base_ram_data;
                        d_ack_d   = 1'b1;
                    end else begin
                        if_rdata_d = base_ram_data;
                        if_ack_d   = 1'b1;
                    end
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_WS: begin
                we_n_d  = 1'b0;
                cnt_d   = 3'(WR_PULSE - 1);
                state_d = S_WP;
            end
            S_WP: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    we_n_d  = 1'b1;
                    state_d = S_WH;
                end
            end
            S_WH: begin
                ce_n_d    = 1'b1;
                data_oe_d = 1'b0;
                be_n_d    = 4'hF;
                d_ack_d   = 1'b1;
                state_d   = S_DONE;
            end
            S_DONE: begin
                // Ack registers were set on entry, so they are high only here.
                last_data_d = gnt_data_q;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign base_ram_data = data_oe_q ? wdata_q : 32'bz;
    assign base_ram_addr = addr_q;
    assign base_ram_ce_n = ce_n_q;
    assign base_ram_oe_n = oe_n_q;
    assign base_ram_we_n = we_n_q;
    assign base_ram_be_n = be_n_q;
    assign if_ack        = if_ack_q;
    assign d_ack         = d_ack_q;
    assign if_rdata      = if_rdata_q;
    assign d_rdata       = d_rdata_q;
    assign busy          = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_sram_arbiter
// Brief   : Directed self-checking bench for sram_arbiter with an async SRAM model.
// Revision: 1.0  initial release
// ============================================================================
module tb_sram_arbiter;
    localparam int P_RD_WAIT  = 3;
    localparam int P_WR_PULSE = 2;
    localparam logic [31:0] PROBE = 32'hA5A5_A5A5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic        reset_btn, if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [3:0]  d_be;
    logic        if_ack, d_ack, busy;
    logic [31:0] if_rdata, d_rdata;
    logic [19:0] ram_addr;
    logic        ram_ce_n, ram_oe_n, ram_we_n;
    logic [3:0]  ram_be_n;
    wire  [31:0] ram_bus;
    logic        probe_en;

    logic        p_if_req, p_d_req, p_d_we;
    logic [31:0] p_if_addr, p_d_addr, p_d_wdata;
    logic [3:0]  p_d_be;
    logic        p_if_ack, p_d_ack, p_busy;
    logic [31:0] p_if_rdata, p_d_rdata;
    logic [19:0] p_ram_addr;
    logic        p_ram_ce_n, p_ram_oe_n, p_ram_we_n;
    logic [3:0]  p_ram_be_n;
    wire  [31:0] p_ram_bus;

    logic [31:0] mem [0:1048575];
    int both_low = 0;

    sram_arbiter dut (
        .clk_50M(clk), .reset_btn(reset_btn),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .busy(busy),
        .base_ram_addr(ram_addr), .base_ram_ce_n(ram_ce_n), .base_ram_oe_n(ram_oe_n),
        .base_ram_we_n(ram_we_n), .base_ram_be_n(ram_be_n), .base_ram_data(ram_bus)
    );

    sram_arbiter #(.RD_WAIT(P_RD_WAIT), .WR_PULSE(P_WR_PULSE)) dut_p (
        .clk_50M(clk), .reset_btn(reset_btn),
        .if_req(p_if_req), .if_addr(p_if_addr), .if_ack(p_if_ack), .if_rdata(p_if_rdata),
        .d_req(p_d_req), .d_we(p_d_we), .d_addr(p_d_addr), .d_be(p_d_be), .d_wdata(p_d_wdata),
        .d_ack(p_d_ack), .d_rdata(p_d_rdata), .busy(p_busy),
        .base_ram_addr(p_ram_addr), .base_ram_ce_n(p_ram_ce_n), .base_ram_oe_n(p_ram_oe_n),
        .base_ram_we_n(p_ram_we_n), .base_ram_be_n(p_ram_be_n), .base_ram_data(p_ram_bus)
    );

    // Async SRAM: drives the bus on a read; the probe exposes an undriven bus.
    assign ram_bus   = (!ram_ce_n && !ram_oe_n && ram_we_n) ? mem[ram_addr] :
                       (probe_en ? PROBE : 32'bz);
    assign p_ram_bus = (!p_ram_ce_n && !p_ram_oe_n && p_ram_we_n) ? mem[p_ram_addr] : 32'bz;

    always @(negedge clk) begin
        if (!ram_ce_n && !ram_we_n)
            for (int b = 0; b < 4; b++)
                if (!ram_be_n[b]) mem[ram_addr][b*8 +: 8] = ram_bus[b*8 +: 8];
        if (!p_ram_ce_n && !p_ram_we_n)
            for (int b = 0; b < 4; b++)
                if (!p_ram_be_n[b]) mem[p_ram_addr][b*8 +: 8] = p_ram_bus[b*8 +: 8];
        if ((!ram_oe_n && !ram_we_n) || (!p_ram_oe_n && !p_ram_we_n)) both_low = both_low + 1;
    end

    task automatic do_access(input logic port_d, input logic we, input logic [31:0] addr,
                             input logic [3:0] be, input logic [31:0] wd,
                             output int lat, output int oe_cyc, output int we_cyc,
                             output logic [3:0] be_seen, output logic [19:0] addr_seen,
                             output logic [31:0] bus_seen, output logic busy_seen);
        lat = -1; oe_cyc = 0; we_cyc = 0; be_seen = 4'hF; addr_seen = '0;
        bus_seen = '0; busy_seen = 1'b0;
        @(posedge clk); #1;
        if (port_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_be = be; d_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (!ram_oe_n) oe_cyc++;
            if (!ram_we_n) begin we_cyc++; bus_seen = ram_bus; end
            if (!ram_ce_n) begin be_seen = ram_be_n; addr_seen = ram_addr; end
            if (busy) busy_seen = 1'b1;
            if (port_d ? d_ack : if_ack) begin lat = i; break; end
        end
        @(posedge clk); #1;
        d_req = 1'b0; if_req = 1'b0;
    endtask

    task automatic do_access_p(input logic port_d, input logic we, input logic [31:0] addr,
                               input logic [31:0] wd, output int lat, output int oe_cyc,
                               output int we_cyc);
        lat = -1; oe_cyc = 0; we_cyc = 0;
        @(posedge clk); #1;
        if (port_d) begin
            p_d_req = 1'b1; p_d_we = we; p_d_addr = addr; p_d_be = 4'hF; p_d_wdata = wd;
        end else begin
            p_if_req = 1'b1; p_if_addr = addr;
        end
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (!p_ram_oe_n) oe_cyc++;
            if (!p_ram_we_n) we_cyc++;
            if (port_d ? p_d_ack : p_if_ack) begin lat = i; break; end
        end
        @(posedge clk); #1;
        p_d_req = 1'b0; p_if_req = 1'b0;
    endtask

    task automatic test_reset;
        int acks;
        @(posedge clk); #1; reset_btn = 1'b1;
        @(posedge clk); @(posedge clk); @(negedge clk);
        n_tests++; if (ram_addr !== 20'd0) begin n_fail++; $display("FAIL reset_addr: got %h expected 00000", ram_addr); end
        n_tests++; if ({ram_ce_n, ram_oe_n, ram_we_n} !== 3'b111) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 111", {ram_ce_n, ram_oe_n, ram_we_n}); end
        n_tests++; if (ram_be_n !== 4'hF) begin n_fail++; $display("FAIL reset_be_n: got %b expected 1111", ram_be_n); end
        n_tests++; if ({busy, if_ack, d_ack} !== 3'b000) begin n_fail++; $display("FAIL reset_busy_acks: got %b expected 000", {busy, if_ack, d_ack}); end
        n_tests++; if ({if_rdata, d_rdata} !== 64'd0) begin n_fail++; $display("FAIL reset_rdata: got %h/%h expected 0/0", if_rdata, d_rdata); end
        probe_en = 1'b1; #1;
        n_tests++; if (ram_bus !== PROBE) begin n_fail++; $display("FAIL reset_bus_z: got %h expected released bus (%h)", ram_bus, PROBE); end
        probe_en = 1'b0;
        @(posedge clk); #1; reset_btn = 1'b0;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (if_ack || d_ack || busy) acks++;
        end
        n_tests++; if (acks != 0) begin n_fail++; $display("FAIL idle_no_ack: got %0d active cycles expected 0", acks); end
    endtask

    task automatic test_single_read;
        int lat, oe_c, we_c; logic [3:0] be_s; logic [19:0] a_s; logic [31:0] bus_s; logic bz;
        mem[20'h00001] = 32'h00A0_0093;
        do_access(1'b0, 1'b0, 32'h8000_0004, 4'h0, 32'h0, lat, oe_c, we_c, be_s, a_s, bus_s, bz);
        n_tests++; if (lat != 4) begin n_fail++; $display("FAIL read_latency: got %0d expected 4", lat); end
        n_tests++; if (oe_c != 2) begin n_fail++; $display("FAIL read_oe_cycles: got %0d expected 2", oe_c); end
        n_tests++; if (a_s !== 20'h00001) begin n_fail++; $display("FAIL read_addr: got %h expected 00001", a_s); end
        n_tests++; if (be_s !== 4'h0) begin n_fail++; $display("FAIL read_be_n: got %b expected 0000", be_s); end
        n_tests++; if (if_rdata !== 32'h00A0_0093) begin n_fail++; $display("FAIL read_data: got %h expected 00a00093", if_rdata); end
        n_tests++; if (bz !== 1'b1) begin n_fail++; $display("FAIL read_busy: got %b expected 1", bz); end
    endtask

    task automatic test_byte_write;
        int lat, oe_c, we_c; logic [3:0] be_s; logic [19:0] a_s; logic [31:0] bus_s; logic bz;
        mem[20'hC0000] = 32'h1122_3344;
        do_access(1'b1, 1'b1, 32'h8030_0000, 4'b0100, 32'h0004_0000, lat, oe_c, we_c, be_s, a_s, bus_s, bz);
        n_tests++; if (lat != 5) begin n_fail++; $display("FAIL write_latency: got %0d expected 5", lat); end
        n_tests++; if (we_c != 1) begin n_fail++; $display("FAIL write_we_cycles: got %0d expected 1", we_c); end
        n_tests++; if (be_s !== 4'b1011) begin n_fail++; $display("FAIL write_be_n: got %b expected 1011", be_s); end
        n_tests++; if (a_s !== 20'hC0000) begin n_fail++; $display("FAIL write_addr: got %h expected c0000", a_s); end
        n_tests++; if (bus_s !== 32'h0004_0000) begin n_fail++; $display("FAIL write_bus: got %h expected 00040000", bus_s); end
        n_tests++; if (mem[20'hC0000] !== 32'h1104_3344) begin n_fail++; $display("FAIL write_mem: got %h expected 11043344", mem[20'hC0000]); end
        n_tests++; if (if_rdata !== 32'h00A0_0093) begin n_fail++; $display("FAIL rdata_hold: got %h expected 00a00093", if_rdata); end
    endtask

    task automatic test_contention;
        int d_t, f_t;
        mem[20'h00100] = 32'hDEAD_0001;
        mem[20'h00102] = 32'h1234_5678;
        mem[20'h00200] = 32'hF00D_0002;
        @(posedge clk); #1;
        reset_btn = 1'b1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8000_0400;
        if_req = 1'b1; if_addr = 32'h8000_0800;
        @(posedge clk); @(posedge clk); #1; reset_btn = 1'b0;
        for (int round = 0; round < 2; round++) begin
            d_t = -1; f_t = -1;
            for (int i = 1; i <= 40; i++) begin
                @(negedge clk);
                if (d_ack && d_t < 0) d_t = i;
                if (if_ack && f_t < 0) f_t = i;
                @(posedge clk); #1;
                if (d_t >= 0) d_req = 1'b0;
                if (f_t >= 0) if_req = 1'b0;
                if (d_t >= 0 && f_t >= 0) break;
            end
            n_tests++; if (d_t != 4) begin n_fail++; $display("FAIL contention_data_first_r%0d: got ack at %0d expected 4", round, d_t); end
            n_tests++; if (f_t != 8) begin n_fail++; $display("FAIL contention_fetch_second_r%0d: got ack at %0d expected 8", round, f_t); end
            n_tests++; if (if_rdata !== 32'hF00D_0002) begin n_fail++; $display("FAIL contention_if_rdata_r%0d: got %h expected f00d0002", round, if_rdata); end
            if (round == 0) begin
                n_tests++; if (d_rdata !== 32'hDEAD_0001) begin n_fail++; $display("FAIL contention_d_rdata_r0: got %h expected dead0001", d_rdata); end
                d_req = 1'b1; d_addr = 32'h8000_0408;
                if_req = 1'b1;
            end else begin
                n_tests++; if (d_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL contention_d_rdata_r1: got %h expected 12345678", d_rdata); end
            end
        end
    endtask

    task automatic test_reset_mid_write;
        int lat, oe_c, we_c, acks; logic [3:0] be_s; logic [19:0] a_s; logic [31:0] bus_s; logic bz;
        logic seen_wp;
        seen_wp = 1'b0;
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8000_0C00; d_be = 4'hF; d_wdata = 32'h5A5A_A5A5;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!ram_we_n) begin seen_wp = 1'b1; break; end
        end
        n_tests++; if (!seen_wp) begin n_fail++; $display("FAIL midwr_reach_wp: got no WE# pulse expected one"); end
        reset_btn = 1'b1;
        @(posedge clk); #1; d_req = 1'b0;
        @(negedge clk);
        n_tests++; if ({ram_ce_n, ram_oe_n, ram_we_n, ram_be_n} !== 7'h7F) begin n_fail++; $display("FAIL midwr_pins: got %b expected 1111111", {ram_ce_n, ram_oe_n, ram_we_n, ram_be_n}); end
        probe_en = 1'b1; #1;
        n_tests++; if (ram_bus !== PROBE) begin n_fail++; $display("FAIL midwr_bus_z: got %h expected released bus (%h)", ram_bus, PROBE); end
        probe_en = 1'b0;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            if (d_ack || busy) acks++;
            @(negedge clk);
            if (i == 1) begin @(posedge clk); #1; reset_btn = 1'b0; end
        end
        n_tests++; if (acks != 0) begin n_fail++; $display("FAIL midwr_no_ack: got %0d active cycles expected 0", acks); end
        do_access(1'b0, 1'b0, 32'h8000_0004, 4'h0, 32'h0, lat, oe_c, we_c, be_s, a_s, bus_s, bz);
        n_tests++; if (lat != 4 || if_rdata !== 32'h00A0_0093) begin n_fail++; $display("FAIL midwr_recover_read: got lat %0d data %h expected 4 00a00093", lat, if_rdata); end
    endtask

    task automatic test_param_sweep;
        int lat, oe_c, we_c;
        mem[20'h00040] = 32'hCAFE_BABE;
        mem[20'h00041] = 32'h0;
        do_access_p(1'b0, 1'b0, 32'h8000_0100, 32'h0, lat, oe_c, we_c);
        n_tests++; if (lat != 6) begin n_fail++; $display("FAIL sweep_read_latency: got %0d expected 6", lat); end
        n_tests++; if (oe_c != 4) begin n_fail++; $display("FAIL sweep_read_oe: got %0d expected 4", oe_c); end
        n_tests++; if (p_if_rdata !== 32'hCAFE_BABE) begin n_fail++; $display("FAIL sweep_read_data: got %h expected cafebabe", p_if_rdata); end
        do_access_p(1'b1, 1'b1, 32'h8000_0104, 32'h1357_9BDF, lat, oe_c, we_c);
        n_tests++; if (lat != 6) begin n_fail++; $display("FAIL sweep_write_latency: got %0d expected 6", lat); end
        n_tests++; if (we_c != 2) begin n_fail++; $display("FAIL sweep_write_we: got %0d expected 2", we_c); end
        n_tests++; if (mem[20'h00041] !== 32'h1357_9BDF) begin n_fail++; $display("FAIL sweep_write_mem: got %h expected 13579bdf", mem[20'h00041]); end
    endtask

    task automatic test_pin_rules;
        n_tests++; if (both_low != 0) begin n_fail++; $display("FAIL oe_we_overlap: got %0d cycles expected 0", both_low); end
    endtask

    initial begin
        reset_btn = 1'b1; probe_en = 1'b0;
        if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_be = '0; d_wdata = '0;
        p_if_req = 1'b0; p_if_addr = '0; p_d_req = 1'b0; p_d_we = 1'b0; p_d_addr = '0;
        p_d_be = '0; p_d_wdata = '0;
        test_reset;
        test_single_read;
        test_byte_write;
        test_contention;
        test_reset_mid_write;
        test_param_sweep;
        test_pin_rules;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
